systolic_fir_chain: RTL and testbench
=====================================

SYSTOLIC_FIR_CHAIN -- requirements
Module: systolic_fir_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 4, signed input sample width.
REQ-002 SHALL have parameter COEF_W, default 8, signed coefficient width.
REQ-003 SHALL have parameter NTAPS, default 8, tap count, range 2..32.
REQ-004 SHALL have parameter ACC_W, default 16, internal accumulator width; must be at least DATA_W+COEF_W+clog2(NTAPS), otherwise elaboration error.
REQ-005 SHALL have parameter OUT_W, default 12, output width, at most ACC_W.
REQ-006 SHALL have parameter SHIFT, default 0, output right-shift amount, range 0..ACC_W-OUT_W.
REQ-007 SHALL have port clk, input, 1 bit, sole clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL have port in_valid, input, 1 bit; x_in carries a real sample this cycle.
REQ-010 SHALL have port x_in, input, DATA_W bits, signed sample.
REQ-011 SHALL have port coef_wr, input, 1 bit, coefficient write strobe.
REQ-012 SHALL have port coef_addr, input, clog2(NTAPS) bits, tap index.
REQ-013 SHALL have port coef_data, input, COEF_W bits, signed coefficient.
REQ-014 SHALL have port out_valid, output, 1 bit, y_out corresponds to a valid input sample.
REQ-015 SHALL have port y_out, output, OUT_W bits, signed filtered sample.
REQ-016 SHALL have port sat, output, 1 bit, y_out was clipped this cycle.

Function
REQ-017 Each tap k SHALL be a systolic slice: sample path of two registers, registered product c[k]*x, and registered sum acc_out[k] = acc_out[k-1] + product[k], with acc_out[-1] = 0.
REQ-018 The sample entering tap 0 SHALL be x_in when in_valid=1 and zero otherwise (zero-stuffing for upsampling); the pipeline advances every cycle with no stall.
REQ-019 With samples s(t) entering at cycle t, the raw accumulator at the chain end SHALL equal the sum over j of c[j]*s(t-NTAPS-3-j), computed exactly in ACC_W bits.
REQ-020 The output stage SHALL register y_out from that accumulator: when SHIFT>0, add 2^(SHIFT-1), then arithmetic-shift right by SHIFT, then saturate to the signed OUT_W range; when SHIFT=0, saturate only.
REQ-021 Total latency from x_in to the c[0] contribution in y_out SHALL be exactly NTAPS+4 cycles.
REQ-022 sat SHALL be 1 in the same cycle y_out is clipped to the max or min value, and 0 otherwise; it is not sticky.
REQ-023 out_valid SHALL be in_valid delayed by exactly NTAPS+4 cycles.
REQ-024 When coef_wr=1, c[coef_addr] SHALL update at the clock edge; the new value is used by the product register from the following cycle, so no partial-width value is ever used.
REQ-025 A coef_addr value of NTAPS or above SHALL make the write ignored.
REQ-026 A coefficient write during streaming SHALL be permitted; outputs in flight mix old and new coefficients per tap, with no other side effect.
REQ-027 Coefficient writes SHALL have no handshake; one write per cycle is allowed back-to-back.

Reset
REQ-028 While rst=1, SHALL clear all sample, product, accumulator, valid-delay and output registers to 0, giving out_valid=0, y_out=0 and sat=0 on the cycle after rst is sampled high.
REQ-029 Reset SHALL clear all coefficients to 0.
REQ-030 A coef_wr asserted while rst=1 SHALL be ignored.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight samples; after rst falls, the first valid output appears NTAPS+4 cycles after the first in_valid.

Verification
REQ-032 Impulse: defaults, c[k]=k+1, single x_in=1 with in_valid -> y_out = 1,2,...,8 on cycles 12..19 after input, with out_valid=1 only on cycle 12.
REQ-033 Saturation: all c=127, x_in=-8 held valid, OUT_W=12 -> y_out reaches -2048 with sat=1; with all c=-128 it reaches 2047 with sat=1.
REQ-034 Upsample-by-4 with zero stuffing: c = 1,2,3,4,4,3,2,1, x_in=2 valid every 4th cycle -> steady y_out period-4 pattern 10,10,10,10 (flat interpolation); out_valid every 4th cycle.
REQ-035 Rounding: SHIFT=2 and accumulator value 6 -> y_out=2; accumulator value -6 -> y_out=-1.
REQ-036 Reset mid-stream: rst pulsed 1 cycle during random streaming -> y_out=0 and out_valid=0 until the new data latency expires; coefficients read back as 0, so y_out stays 0 until they are rewritten.
REQ-037 Out-of-range write: coef_addr=NTAPS with NTAPS not a power of 2 -> impulse response unchanged.

Source files
------------

// File: rtl/systolic_fir_chain.sv
// Systolic transposed-timing FIR: per-tap double-registered sample path, registered
// product and running sum, followed by a round/shift/saturate output register.
module systolic_fir_chain #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 8,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 12,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   x_in,
  input  logic                       coef_wr,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       out_valid,
  output logic signed [OUT_W-1:0]    y_out,
  output logic                       sat
);

  localparam int AW = $clog2(NTAPS);
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'((2**SHIFT) / 2);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((2**(OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  if (NTAPS < 2 || NTAPS > 32) begin : g_bad_ntaps
    $error("systolic_fir_chain: NTAPS must be in 2..32");
  end
  if (ACC_W < DATA_W + COEF_W + $clog2(NTAPS)) begin : g_bad_acc
    $error("systolic_fir_chain: ACC_W too narrow for exact accumulation");
  end
  if (OUT_W > ACC_W) begin : g_bad_out
    $error("systolic_fir_chain: OUT_W must not exceed ACC_W");
  end
  if (SHIFT < 0 || SHIFT > ACC_W - OUT_W) begin : g_bad_shift
    $error("systolic_fir_chain: SHIFT out of range");
  end

  function automatic logic signed [ACC_W:0] rnd_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] w;
    w = (ACC_W+1)'(a);
    return (w + RND) >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] w);
    if (w > MAXV) return MAXV[OUT_W-1:0];
    if (w < MINV) return MINV[OUT_W-1:0];
    return w[OUT_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] acc_end;

  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
    logic signed [DATA_W-1:0] xa_q, xb_q, x_d;
    logic signed [COEF_W-1:0] coef_q;
    logic signed [ACC_W-1:0]  prod_q, acc_q, acc_in_d;

    // Tap 0 takes the zero-stuffed input and an empty partial sum.
    if (gi == 0) begin : g_first
      assign x_d      = in_valid ? x_in : '0;
      assign acc_in_d = '0;
    end else begin : g_rest
      assign x_d      = g_tap[gi-1].xb_q;
      assign acc_in_d = g_tap[gi-1].acc_q;
    end

    if (gi == NTAPS - 1) begin : g_last
      assign acc_end = acc_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        xa_q   <= '0;
        xb_q   <= '0;
        prod_q <= '0;
        acc_q  <= '0;
        coef_q <= '0;
      end else begin
        xa_q   <= x_d;
        xb_q   <= xa_q;
        prod_q <= ACC_W'(xb_q * coef_q);
        acc_q  <= acc_in_d + prod_q;
        if (coef_wr && coef_addr == AW'(gi)) coef_q <= coef_data;
      end
    end
  end

  logic [NTAPS+3:0]        vld_q;
  logic signed [ACC_W:0]   shifted_d;
  logic signed [OUT_W-1:0] y_d, y_q;
  logic                    sat_d, sat_q;

  // Output stage: round, shift and clip the chain-end sum.
  always_comb begin
    shifted_d = rnd_shift(acc_end);
    y_d       = saturate(shifted_d);
    sat_d     = (shifted_d > MAXV) || (shifted_d < MINV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      vld_q <= {vld_q[NTAPS+2:0], in_valid};
      y_q   <= y_d;
      sat_q <= sat_d;
    end
  end

  assign out_valid = vld_q[NTAPS+3];
  assign y_out     = y_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_systolic_fir_chain.sv
// Bench for systolic_fir_chain: two instances (default, and NTAPS=7/SHIFT=2) checked
// every cycle against a convolution model plus directed literal expectations.
module tb_systolic_fir_chain;

  localparam int HMAX = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic iv0, wr0, iv1, wr1;
  logic signed [3:0]  x0, x1;
  logic [2:0]         a0, a1;
  logic signed [7:0]  d0, d1;
  logic               ov0, ov1, sat0, sat1;
  logic signed [11:0] y0, y1;

  systolic_fir_chain u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .x_in(x0), .coef_wr(wr0), .coef_addr(a0),
    .coef_data(d0), .out_valid(ov0), .y_out(y0), .sat(sat0)
  );

  systolic_fir_chain #(.NTAPS(7), .SHIFT(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .x_in(x1), .coef_wr(wr1), .coef_addr(a1),
    .coef_data(d1), .out_valid(ov1), .y_out(y1), .sat(sat1)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int last_rst = -1000;
  bit started = 1'b0;
  int NT[2] = '{8, 7};
  int SH[2] = '{0, 2};
  int s_hist[2][0:HMAX-1];
  bit v_hist[2][0:HMAX-1];
  int c_hist[2][0:HMAX-1][0:7];
  int cm[2][0:7];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // What each instance captured at this edge: stuffed sample, valid, coefficient set.
  task automatic rec(input int d, input logic iv, input int x, input logic wr,
                     input int a, input int dat);
    s_hist[d][cyc] = (!rst && iv) ? x : 0;
    v_hist[d][cyc] = !rst && iv;
    if (rst) begin
      for (int k = 0; k < 8; k++) cm[d][k] = 0;
    end else if (wr && a < NT[d]) begin
      cm[d][a] = dat;
    end
    for (int k = 0; k < 8; k++) c_hist[d][cyc][k] = cm[d][k];
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc >= HMAX) begin
      $display("FAIL history_bound: got edge %0d, limit %0d", cyc, HMAX);
      $fatal(1, "history overflow");
    end
    if (rst) begin
      last_rst = cyc;
      started  = 1'b1;
    end
    rec(0, iv0, int'(x0), wr0, int'(a0), int'(d0));
    rec(1, iv1, int'(x1), wr1, int'(a1), int'(d1));
  end

  // Output after edge e: sum of c_j * s(e-n-3-j), using the coefficient that was
  // in place when tap j formed its product; any reset along the way kills the term.
  function automatic void model(input int d, input int e, output int y, output int s,
                                output int v);
    int n;
    int acc;
    int r;
    n   = NT[d];
    acc = 0;
    for (int j = 0; j < n; j++)
      if (last_rst < e - n - 3 - j)
        acc += c_hist[d][e-n-2+j][j] * s_hist[d][e-n-3-j];
    r = (SH[d] > 0) ? ((acc + (1 << (SH[d] - 1))) >>> SH[d]) : acc;
    s = (r > 2047 || r < -2048) ? 1 : 0;
    y = (r > 2047) ? 2047 : ((r < -2048) ? -2048 : r);
    v = 0;
    if (last_rst < e - n - 3) v = v_hist[d][e-n-3] ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    int ey, es, ev;
    if (started) begin
      model(0, cyc, ey, es, ev);
      chk("model_y0", int'(y0), ey);
      chk("model_sat0", int'(sat0), es);
      chk("model_vld0", int'(ov0), ev);
      model(1, cyc, ey, es, ev);
      chk("model_y1", int'(y1), ey);
      chk("model_sat1", int'(sat1), es);
      chk("model_vld1", int'(ov1), ev);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wcoef(input int d, input int a, input int v);
    if (d == 0) begin
      wr0 = 1'b1; a0 = 3'(a); d0 = 8'(v);
    end else begin
      wr1 = 1'b1; a1 = 3'(a); d1 = 8'(v);
    end
    tick();
    wr0 = 1'b0;
    wr1 = 1'b0;
  endtask

  initial begin
    int up[8];
    int cnt;
    up = '{1, 2, 3, 4, 4, 3, 2, 1};
    rst = 1'b1;
    iv0 = 1'b0; wr0 = 1'b0; x0 = '0; a0 = '0; d0 = '0;
    iv1 = 1'b0; wr1 = 1'b0; x1 = '0; a1 = '0; d1 = '0;
    repeat (3) tick();
    chk("rst_y0", int'(y0), 0);
    chk("rst_vld0", int'(ov0), 0);
    chk("rst_sat0", int'(sat0), 0);
    chk("rst_y1", int'(y1), 0);
    chk("rst_vld1", int'(ov1), 0);
    rst = 1'b0;

    // Impulse through c[k]=k+1.
    for (int k = 0; k < 8; k++) wcoef(0, k, k + 1);
    x0 = 4'sd1; iv0 = 1'b1;
    tick();
    x0 = '0; iv0 = 1'b0;
    repeat (11) tick();
    chk("imp_y_c12", int'(y0), 1);
    chk("imp_vld_c12", int'(ov0), 1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("imp_y", int'(y0), k);
      chk("imp_vld", int'(ov0), 0);
    end

    // Saturation both ways, then confirm sat is not sticky.
    for (int k = 0; k < 8; k++) wcoef(0, k, 127);
    x0 = -4'sd8; iv0 = 1'b1;
    repeat (20) tick();
    chk("sat_neg_y", int'(y0), -2048);
    chk("sat_neg_flag", int'(sat0), 1);
    for (int k = 0; k < 8; k++) wcoef(0, k, -128);
    repeat (20) tick();
    chk("sat_pos_y", int'(y0), 2047);
    chk("sat_pos_flag", int'(sat0), 1);
    iv0 = 1'b0;
    repeat (20) tick();
    chk("sat_clear_y", int'(y0), 0);
    chk("sat_clear_flag", int'(sat0), 0);

    // Upsample by 4 with zero stuffing: x stays 2 but only every 4th cycle is valid.
    for (int k = 0; k < 8; k++) wcoef(0, k, up[k]);
    cnt = 0;
    for (int i = 0; i < 48; i++) begin
      iv0 = (i % 4 == 0);
      x0  = 4'sd2;
      tick();
      if (i >= 40 && i < 44) chk("up_y", int'(y0), 10);
      if (i >= 40) cnt += int'(ov0);
    end
    chk("up_vld_count", cnt, 2);
    iv0 = 1'b0; x0 = '0;

    // Random streaming with coefficient writes and a one-cycle reset mid-stream.
    for (int i = 0; i < 400; i++) begin
      rst = (i == 150);
      iv0 = 1'($urandom_range(0, 1));
      iv1 = 1'($urandom_range(0, 1));
      x0  = 4'($urandom_range(0, 15));
      x1  = 4'($urandom_range(0, 15));
      wr0 = (i == 150) || (!(i > 150 && i < 186) && $urandom_range(0, 4) == 0);
      wr1 = (i == 150) || (!(i > 150 && i < 186) && $urandom_range(0, 4) == 0);
      a0  = 3'($urandom_range(0, 7));
      a1  = 3'($urandom_range(0, 7));
      d0  = 8'($urandom_range(1, 255));
      d1  = 8'($urandom_range(1, 255));
      tick();
      if (i >= 150 && i < 186) begin
        chk("post_rst_y0", int'(y0), 0);
        chk("post_rst_y1", int'(y1), 0);
      end
    end
    rst = 1'b0; iv0 = 1'b0; iv1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;

    // Rounding on the SHIFT=2 instance: accumulator 6 -> 2, -6 -> -1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wcoef(1, 0, 3);
    x1 = 4'sd2; iv1 = 1'b1;
    tick();
    x1 = '0; iv1 = 1'b0;
    repeat (10) tick();
    chk("round_pos_y", int'(y1), 2);
    chk("round_pos_vld", int'(ov1), 1);
    x1 = -4'sd2; iv1 = 1'b1;
    tick();
    x1 = '0; iv1 = 1'b0;
    repeat (10) tick();
    chk("round_neg_y", int'(y1), -1);

    // Out-of-range write on the 7-tap instance leaves the impulse response intact.
    for (int k = 0; k < 7; k++) wcoef(1, k, k + 1);
    wcoef(1, 7, 100);
    x1 = 4'sd4; iv1 = 1'b1;
    tick();
    x1 = '0; iv1 = 1'b0;
    repeat (10) tick();
    for (int k = 1; k <= 7; k++) begin
      chk("oor_imp_y", int'(y1), k);
      tick();
    end
    chk("oor_tail_y", int'(y1), 0);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
